// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between two requesters. A round-robin grant is made
//   combinationally while idle. The granted opcode and operands are latched and
//   drive the ALU for one EXEC cycle. The result, the error bit and the
//   masked Z/V/N flag update are captured at the end of EXEC. The response is
//   then held until the consumer takes it.
//
// Optional feature macro: ALU_ERR_STICKY_EN
//   When defined, err_sticky records any captured alu_error until err_clr.
//   When undefined, err_sticky is tied 0 and err_clr is ignored.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         requester N handshake (N = 0, 1)
//   reqN_op/a/b              requester N opcode and operands
//   alu_in1/in2/opcode       to ALU, always the latched request
//   alu_out, alu_error       from ALU, sampled at the end of EXEC
//   rsp_valid/ready          response handshake
//   rsp_id/data/err          requester index, result and error of response
//   flags                    architectural {Z,V,N}
//   err_sticky, err_clr      sticky error and its clear (optional feature)
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int         WIDTH    = 16,
   parameter int         OPW      = 3,
   parameter logic [2:0] FLAG_RST = 3'b000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [OPW-1:0]   alu_opcode,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_error,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [2:0]       flags,
   output logic             err_sticky,
   input  logic             err_clr
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   typedef struct packed {
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   localparam logic [OPW-1:0] OP0 = OPW'(0);
   localparam logic [OPW-1:0] OP1 = OPW'(1);
   localparam logic [OPW-1:0] OP2 = OPW'(2);
   localparam logic [OPW-1:0] OP4 = OPW'(4);
   localparam logic [OPW-1:0] OP5 = OPW'(5);
   localparam logic [OPW-1:0] OP6 = OPW'(6);

   state_t           r_state;
   logic             r_last_grant;
   req_t             r_req;
   logic             r_id;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_err;
   logic [2:0]       r_flags;

   req_t [1:0]       w_req;
   logic [1:0]       w_valid;
   logic             w_idle;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic             w_upd_all;
   logic             w_upd_z;
   logic [2:0]       w_flags_new;

   assign w_req[0] = '{op: req0_op, a: req0_a, b: req0_b};
   assign w_req[1] = '{op: req1_op, a: req1_a, b: req1_b};
   assign w_valid  = {req1_valid, req0_valid};

   // Grant only while idle. On a tie, the requester that did not win last
   // time goes next. r_last_grant resets to 1, so req0 wins the first tie.
   assign w_idle   = (r_state == S_IDLE);
   assign w_gnt1   = w_idle & w_valid[1] & (~w_valid[0] | ~r_last_grant);
   assign w_gnt0   = w_idle & w_valid[0] & ~w_gnt1;
   assign w_accept = w_gnt0 | w_gnt1;

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Flag update mask by opcode. Add and sub update all flags. The logical
   // and shift group updates Z only. The remaining opcodes leave flags alone.
   always_comb begin
      w_upd_all = 1'b0;
      w_upd_z   = 1'b0;
      case (r_req.op)
         OP0, OP1:           w_upd_all = 1'b1;
         OP2, OP4, OP5, OP6: w_upd_z   = 1'b1;
         default: ;
      endcase
   end

   // Flags come from the result and alu_error, not from any ALU flag output.
   always_comb begin
      w_flags_new = r_flags;
      if (w_upd_all || w_upd_z)
         w_flags_new[2] = (alu_out == '0);
      if (w_upd_all) begin
         w_flags_new[1] = alu_error;
         w_flags_new[0] = alu_out[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_req        <= '0;
         r_id         <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_flags      <= FLAG_RST;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req        <= w_gnt1 ? w_req[1] : w_req[0];
                  r_id         <= w_gnt1;
                  r_last_grant <= w_gnt1;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_data  <= alu_out;
               r_rsp_err   <= alu_error;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_flags     <= w_flags_new;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               // After the handshake, return to IDLE. A pending request is
               // granted there on the next cycle.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_in1    = r_req.a;
   assign alu_in2    = r_req.b;
   assign alu_opcode = r_req.op;

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign flags      = r_flags;

`ifdef ALU_ERR_STICKY_EN
   logic r_err_sticky;

   // A set at the capture edge wins over a clear at the same edge.
   always_ff @(posedge clk) begin
      if (rst)
         r_err_sticky <= 1'b0;
      else if (r_state == S_EXEC && alu_error)
         r_err_sticky <= 1'b1;
      else if (err_clr)
         r_err_sticky <= 1'b0;
   end

   assign err_sticky = r_err_sticky;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign err_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int WIDTH = 16;
   localparam int OPW   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [OPW-1:0]   req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
   logic [OPW-1:0]   alu_opcode;
   logic             alu_error;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [WIDTH-1:0] rsp_data;
   logic [2:0]       flags;
   logic             err_sticky, err_clr;

   int checks = 0;
   int errors = 0;

`ifdef ALU_ERR_STICKY_EN
   localparam logic STICKY_ON = 1'b1;
`else
   localparam logic STICKY_ON = 1'b0;
`endif

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .FLAG_RST(3'b000)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_error(alu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .flags(flags),
      .err_sticky(err_sticky), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // External ALU stand-in: add/sub with signed overflow, and/or/xor, else pass a
   logic [WIDTH-1:0] t_r;
   always_comb begin
      t_r       = alu_in1;
      alu_error = 1'b0;
      case (alu_opcode)
         3'd0: begin
            t_r = alu_in1 + alu_in2;
            alu_error = (alu_in1[15] == alu_in2[15]) && (t_r[15] != alu_in1[15]);
         end
         3'd1: begin
            t_r = alu_in1 - alu_in2;
            alu_error = (alu_in1[15] != alu_in2[15]) && (t_r[15] != alu_in1[15]);
         end
         3'd2: t_r = alu_in1 & alu_in2;
         3'd3: t_r = alu_in1 | alu_in2;
         3'd4: t_r = alu_in1 ^ alu_in2;
         default: ;
      endcase
      alu_out = t_r;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction with rsp_ready held high: accept, EXEC, RESP, back to IDLE
   task automatic run_op(input logic id, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_d,
                         input logic exp_e, input logic [2:0] exp_f, input logic exp_s);
      rsp_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req0_valid = 1'b0;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req1_valid = 1'b0;
      end
      #1;
      chk("grant_ready", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 16'hDEAD; req1_a = 16'hBEEF;
      #1;
      chk("exec_ready", {req1_ready, req0_ready}, 2'b00);
      chk("exec_rsp_valid", rsp_valid, 1'b0);
      chk("exec_alu_in", {alu_opcode, alu_in1, alu_in2}, {op, a, b});
      tick();
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_fields", {rsp_id, rsp_err, rsp_data}, {id, exp_e, exp_d});
      chk("flags", flags, exp_f);
      chk("err_sticky", err_sticky, exp_s);
      tick();
      chk("rsp_done", rsp_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0; err_clr = 0;
      req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 19'h0);
      chk("rst_flags", flags, 3'b000);
      chk("rst_alu_in", {alu_opcode, alu_in1, alu_in2}, 35'h0);
      chk("rst_sticky", err_sticky, 1'b0);
      chk("rst_ready", {req1_ready, req0_ready}, 2'b00);

      // Overflow add, then flag masks per opcode group
      run_op(1'b0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 3'b011, STICKY_ON);
      run_op(1'b0, 3'd2, 16'h00FF, 16'hFF00, 16'h0000, 1'b0, 3'b111, STICKY_ON);
      run_op(1'b1, 3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b100, STICKY_ON);
      run_op(1'b0, 3'd3, 16'h8000, 16'h0000, 16'h8000, 1'b0, 3'b100, STICKY_ON);
      run_op(1'b1, 3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0, 3'b000, STICKY_ON);
      run_op(1'b0, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b000, STICKY_ON);

      // Response held with rsp_ready low while req1 waits
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'd4; req0_a = 16'h00FF; req0_b = 16'h0F0F;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h0002; req1_b = 16'h0003;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h0FF0});
         chk("hold_req1_ready", req1_ready, 1'b0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("hs_cycle_req1_ready", req1_ready, 1'b0);
      tick();
      chk("after_hs_req1_ready", req1_ready, 1'b1);
      chk("after_hs_rsp_valid", rsp_valid, 1'b0);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("req1_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h0005});
      chk("req1_flags", flags, 3'b000);
      tick();

      // Overflow capture with err_clr also asserted: set wins
      err_clr = 1'b1;
      run_op(1'b0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 3'b011, STICKY_ON);
      tick();
      err_clr = 1'b0;
      chk("sticky_clr_alone", err_sticky, 1'b0);
      run_op(1'b1, 3'd0, 16'h4000, 16'h4000, 16'h8000, 1'b1, 3'b011, STICKY_ON);

      // Reset during EXEC drops the operation
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0000; req0_b = 16'h0000;
      tick();
      req0_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_rsp", {rsp_valid, rsp_data}, 17'h0);
      chk("mid_rst_flags", flags, 3'b000);
      chk("mid_rst_sticky", err_sticky, 1'b0);
      tick();
      chk("mid_rst_no_rsp", rsp_valid, 1'b0);

      // Both requesters valid every cycle: grants alternate starting with req0
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001;
      req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h0005; req1_b = 16'h0002;
      rsp_ready  = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_grant", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
         tick();
         chk("rr_exec_ready", {req1_ready, req0_ready}, 2'b00);
         tick();
         chk("rr_rsp", {rsp_valid, rsp_id, rsp_data},
             {1'b1, 1'(k % 2), (k % 2) ? 16'h0003 : 16'h0002});
         chk("rr_resp_ready", {req1_ready, req0_ready}, 2'b00);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
